// File: rtl/plane_pwm_controller_db.sv
`default_nettype none
// ============================================================================
// plane_pwm_controller_db
// Double-buffered OUT_NUM-channel PWM plane driver fed by a strobed MCU byte bus.
// Revision: 1.0
// ============================================================================
module plane_pwm_controller_db #(
  parameter int OUT_NUM         = 64,
  parameter int D_WIDTH         = 8,
  parameter int C_WIDTH         = 5,
  parameter int PWM_TOP         = 30,
  parameter int MCU_CLK_DIVIDER = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [D_WIDTH-1:0] dataIn,
  input  logic               dataEn,
  input  logic               rs,
  output logic [OUT_NUM-1:0] pwmOut,
  output logic               mcuClk,
  output logic               swapPending
);

  localparam int                 A_WIDTH = $clog2(OUT_NUM);
  localparam logic [C_WIDTH-1:0] c_top   = C_WIDTH'(PWM_TOP);
  localparam logic [A_WIDTH-1:0] c_last  = A_WIDTH'(OUT_NUM - 1);
  localparam logic [A_WIDTH:0]   c_num   = (A_WIDTH + 1)'(OUT_NUM);

  logic [C_WIDTH-1:0] cnt_q, cnt_d;
  logic               disp_bank_q, disp_bank_d;
  logic               swap_pending_q, swap_pending_d;
  logic [A_WIDTH-1:0] addr_q, addr_d;
  logic               inc_dec_q, inc_dec_d;
  logic               pwm_enabled_q, pwm_enabled_d;
  logic               old_data_en_q, old_data_en_d;
  logic [OUT_NUM-1:0] pwm_out_q, pwm_out_d;
  logic [C_WIDTH-1:0] bank_q [2][OUT_NUM];
  logic [C_WIDTH-1:0] bank_d [2][OUT_NUM];

  logic               strobe_w;
  logic               take_swap_w;
  logic               write_bank_w;
  logic [7:0]         cmd_w;

  assign strobe_w     = ~dataEn & old_data_en_q;
  assign take_swap_w  = (cnt_q == c_top) & swap_pending_q;
  // The write bank is taken from the current register, so a write in the swap
  // cycle lands in the bank that is about to become visible.
  assign write_bank_w = ~disp_bank_q;
  assign cmd_w        = dataIn[7:0];

  always_comb begin
    cnt_d          = (cnt_q == c_top) ? '0 : cnt_q + 1'b1;
    old_data_en_d  = dataEn;
    disp_bank_d    = disp_bank_q ^ take_swap_w;
    swap_pending_d = swap_pending_q & ~take_swap_w;
    addr_d         = addr_q;
    inc_dec_d      = inc_dec_q;
    pwm_enabled_d  = pwm_enabled_q;
    bank_d         = bank_q;

    if (strobe_w) begin
      if (rs) begin
        if (cmd_w == 8'h01) begin
          for (int i = 0; i < OUT_NUM; i++) begin
            bank_d[write_bank_w][i] = '0;
          end
        end else if (cmd_w[7:1] == 7'h01) begin
          addr_d = '0;
        end else if (cmd_w[7:2] == 6'h01) begin
          inc_dec_d = cmd_w[1];
        end else if (cmd_w[7:3] == 5'h01) begin
          pwm_enabled_d = cmd_w[2];
        end else if (cmd_w[7:4] == 4'h1) begin
          swap_pending_d = 1'b1;
        end else if (cmd_w[7]) begin
          addr_d = cmd_w[A_WIDTH-1:0];
        end
      end else begin
        if ({1'b0, addr_q} < c_num) begin
          bank_d[write_bank_w][addr_q] = dataIn[C_WIDTH-1:0];
        end
        // Step is explicit at both wrap points so a non-power-of-two OUT_NUM still wraps
        if (inc_dec_q) begin
          addr_d = (addr_q == c_last) ? '0 : addr_q + 1'b1;
        end else begin
          addr_d = (addr_q == '0) ? c_last : addr_q - 1'b1;
        end
      end
    end
  end

  always_comb begin
    pwm_out_d = '0;
    for (int i = 0; i < OUT_NUM; i++) begin
      pwm_out_d[i] = pwm_enabled_q & (cnt_q < bank_q[disp_bank_q][i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q          <= '0;
      disp_bank_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      addr_q         <= '0;
      inc_dec_q      <= 1'b0;
      pwm_enabled_q  <= 1'b0;
      old_data_en_q  <= 1'b0;
      pwm_out_q      <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < OUT_NUM; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      cnt_q          <= cnt_d;
      disp_bank_q    <= disp_bank_d;
      swap_pending_q <= swap_pending_d;
      addr_q         <= addr_d;
      inc_dec_q      <= inc_dec_d;
      pwm_enabled_q  <= pwm_enabled_d;
      old_data_en_q  <= old_data_en_d;
      pwm_out_q      <= pwm_out_d;
      bank_q         <= bank_d;
    end
  end

  assign pwmOut      = pwm_out_q;
  assign mcuClk      = cnt_q[MCU_CLK_DIVIDER];
  assign swapPending = swap_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_plane_pwm_controller_db.sv
`default_nettype none
// ============================================================================
// tb_plane_pwm_controller_db
// Bench for plane_pwm_controller_db: directed scenarios plus random bus traffic.
// Revision: 1.0
// ============================================================================
module tb_plane_pwm_controller_db;

  localparam int PWM_TOP = 30;
  localparam int PERIOD  = PWM_TOP + 1;

  logic        clk;
  logic        reset;
  logic [7:0]  dataIn;
  logic        dataEn;
  logic        rs;
  logic [63:0] p0;
  logic [47:0] p1;
  logic        mcu0, mcu1, swp0, swp1;

  plane_pwm_controller_db #(.OUT_NUM(64)) dut0 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataEn(dataEn), .rs(rs),
    .pwmOut(p0), .mcuClk(mcu0), .swapPending(swp0)
  );

  plane_pwm_controller_db #(.OUT_NUM(48)) dut1 (
    .clk(clk), .reset(reset), .dataIn(dataIn), .dataEn(dataEn), .rs(rs),
    .pwmOut(p1), .mcuClk(mcu1), .swapPending(swp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: plain per-instance arrays stepped once per clock
  int           nch [2] = '{64, 48};
  int           amod[2] = '{64, 64};
  int           m_bank[2][2][128];
  int           m_addr[2];
  bit           m_inc[2], m_en[2], m_disp[2], m_pend[2];
  bit           m_old;
  int           m_cyc;
  logic [127:0] m_pwm[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++) for (int i = 0; i < 128; i++) m_bank[k][b][i] = 0;
      m_addr[k] = 0; m_inc[k] = 0; m_en[k] = 0; m_disp[k] = 0; m_pend[k] = 0;
      m_pwm[k] = '0;
    end
    m_old = 0;
    m_cyc = 0;
  endtask

  task automatic model_step();
    int         c, wb;
    bit         ev;
    logic [7:0] d;
    c  = m_cyc % PERIOD;
    ev = !dataEn && m_old;
    d  = dataIn;
    for (int k = 0; k < 2; k++) begin
      wb = m_disp[k] ? 0 : 1;
      m_pwm[k] = '0;
      for (int i = 0; i < nch[k]; i++) m_pwm[k][i] = m_en[k] && (c < m_bank[k][m_disp[k]][i]);
      if (c == PWM_TOP && m_pend[k]) begin
        m_disp[k] = !m_disp[k];
        m_pend[k] = 0;
      end
      if (ev) begin
        if (rs) begin
          if (d == 8'h01) for (int i = 0; i < 128; i++) m_bank[k][wb][i] = 0;
          else if (d >= 2 && d <= 3) m_addr[k] = 0;
          else if (d >= 4 && d <= 7) m_inc[k] = d[1];
          else if (d >= 8 && d <= 15) m_en[k] = d[2];
          else if (d >= 16 && d <= 31) m_pend[k] = 1;
          else if (d >= 128) m_addr[k] = int'(d) % amod[k];
        end else begin
          if (m_addr[k] < nch[k]) m_bank[k][wb][m_addr[k]] = int'(d) % 32;
          if (m_inc[k]) m_addr[k] = (m_addr[k] == nch[k] - 1) ? 0 : (m_addr[k] + 1) % amod[k];
          else          m_addr[k] = (m_addr[k] == 0) ? nch[k] - 1 : m_addr[k] - 1;
        end
      end
    end
    m_old = dataEn;
    m_cyc++;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("pwm0", p0, m_pwm[0][63:0]);
      chk("pwm1", p1, m_pwm[1][47:0]);
      chk("mcu0", mcu0, ((m_cyc % PERIOD) >> 2) & 1);
      chk("mcu1", mcu1, ((m_cyc % PERIOD) >> 2) & 1);
      chk("swp0", swp0, m_pend[0]);
      chk("swp1", swp1, m_pend[1]);
    end
  end

  task automatic bus(input bit r, input logic [7:0] d, input int width);
    @(negedge clk);
    rs = r; dataIn = d; dataEn = 1'b1;
    repeat (width) @(negedge clk);
    dataEn = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);
    bus(1'b1, d, 1);
  endtask

  task automatic dat(input logic [7:0] d);
    bus(1'b0, d, 1);
  endtask

  task automatic wait_swap();
    int n;
    cmd(8'h10);
    n = 0;
    while (swp0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("swap_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic align(input int target);
    int g;
    g = 0;
    while ((m_cyc % PERIOD) != target && g < 64) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic count_high(input int k, input int ch, output int n);
    n = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      n += (k == 0) ? int'(p0[ch]) : int'(p1[ch]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset  = 1'b0;
    dataEn = 1'b0;
    #1;
    chk("async_rst_pwm", p0, 0);
    chk("async_rst_swp", swp0, 0);
    chk("async_rst_mcu", mcu0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [7:0] cmd_list[10] = '{8'h01, 8'h02, 8'h05, 8'h06, 8'h0C, 8'h0C, 8'h10, 8'h08, 8'h40, 8'h00};

  initial begin
    int         n, g;
    logic [7:0] d;
    bit         r;

    reset = 1'b0; dataEn = 1'b0; rs = 1'b0; dataIn = '0;
    repeat (3) @(negedge clk);
    chk("rst_pwm0", p0, 0);
    chk("rst_swp0", swp0, 0);
    chk("rst_mcu0", mcu0, 0);
    chk_on = 1'b1;
    reset  = 1'b1;

    // Write/dim
    cmd(8'h06); cmd(8'h80); dat(8'd5); dat(8'd10); cmd(8'h0C);
    wait_swap();
    count_high(0, 0, n); chk("t2_ch0", n, 5);
    count_high(0, 1, n); chk("t2_ch1", n, 10);
    count_high(0, 2, n); chk("t2_ch2", n, 0);
    count_high(1, 1, n); chk("t2_dut1_ch1", n, 10);

    // Address wrap in both directions
    cmd(8'h04); cmd(8'h02); dat(8'd7); dat(8'd3); dat(8'd9);
    wait_swap();
    count_high(0, 0, n);  chk("t3_ch0", n, 7);
    count_high(0, 63, n); chk("t3_ch63", n, 3);
    count_high(0, 62, n); chk("t3_ch62", n, 9);
    cmd(8'h06); cmd(8'hBF); dat(8'd11); dat(8'd13);
    wait_swap();
    count_high(0, 63, n); chk("t3_inc_ch63", n, 11);
    count_high(0, 0, n);  chk("t3_inc_ch0", n, 13);
    count_high(0, 1, n);  chk("t3_inc_ch1", n, 10);

    // Double buffer: hidden write is invisible until the swap at the period end
    cmd(8'h80); dat(8'd20);
    count_high(0, 0, n); chk("t4_hidden", n, 13);
    align(5);
    cmd(8'h10);
    chk("t4_pending", swp0, 1);
    g = 0;
    while (swp0 && g < 64) begin
      @(negedge clk);
      g++;
    end
    chk("t4_flip_cnt0", m_cyc % PERIOD, 0);
    count_high(0, 0, n); chk("t4_new_ch0", n, 20);

    // Boundaries and clear
    cmd(8'h85); dat(8'd12);
    wait_swap();
    count_high(0, 5, n); chk("t5_ch5", n, 12);
    cmd(8'h85); dat(8'd25); cmd(8'h01);
    count_high(0, 5, n); chk("t5_clear_hidden", n, 12);
    wait_swap();
    count_high(0, 5, n); chk("t5_cleared_ch5", n, 0);
    count_high(0, 0, n); chk("t5_cleared_ch0", n, 0);
    cmd(8'h80); dat(8'd0); dat(8'd31);
    wait_swap();
    count_high(0, 0, n); chk("t5_duty0", n, 0);
    count_high(0, 1, n); chk("t5_duty31", n, 31);
    count_high(1, 1, n); chk("t5_dut1_duty31", n, 31);
    cmd(8'h08);
    chk("t5_disable", p0, 0);

    // Strobe held low gives exactly one write; reserved command; out-of-range address
    cmd(8'h80);
    @(negedge clk);
    rs = 1'b0; dataIn = 8'd22; dataEn = 1'b1;
    @(negedge clk);
    dataEn = 1'b0;
    repeat (10) @(negedge clk);
    dat(8'd23);
    cmd(8'h40);
    chk("t6_reserved_swp", swp0, 0);
    cmd(8'h0C);
    wait_swap();
    count_high(0, 0, n); chk("t6_hold_ch0", n, 22);
    count_high(0, 1, n); chk("t6_hold_ch1", n, 23);
    cmd(8'hB2); dat(8'd17); dat(8'd19);
    wait_swap();
    count_high(0, 50, n); chk("t6_ch50", n, 17);
    count_high(0, 51, n); chk("t6_ch51", n, 19);

    // Reset mid-period with a swap pending and non-zero banks
    align(5);
    cmd(8'h10);
    do_reset();
    repeat (5) @(negedge clk);
    chk("post_rst_swp", swp0, 0);
    chk("post_rst_pwm", p0, 0);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      r = 1'($urandom_range(0, 1));
      if (r) begin
        g = $urandom_range(0, 11);
        d = (g < 10) ? cmd_list[g] : 8'($urandom);
      end else begin
        d = 8'($urandom);
      end
      bus(r, d, $urandom_range(1, 3));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
